// File: rtl/stream_mux_pkg.sv
// ============================================================================
// Module      : stream_mux_pkg
// Description : Shared constants for the N-channel stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;
  localparam int W_MIN = 1;
  localparam int W_MAX = 64;

endpackage

`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first request at or above
//               ptr, wrapping N-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  // One spare bit keeps ptr+k from overflowing before the wrap subtraction.
  always_comb begin : p_scan
    logic [SW:0] w_idx;
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, ptr} + (SW+1)'(k);
      if (w_idx >= (SW+1)'(N))
        w_idx = w_idx - (SW+1)'(N);
      if (!grant_valid && req[w_idx[SW-1:0]]) begin
        grant       = w_idx[SW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_mux_n.sv
// ============================================================================
// Module      : stream_mux_n
// Description : N-channel W-bit valid/ready stream mux with fixed or
//               round-robin selection and a registered output stage.
//               Define STREAM_MUX_SKID_EN to add a one-entry skid register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  generate
    if (N < N_MIN || N > N_MAX) begin : g_bad_n
      $error("stream_mux_n: N must be within 2..32");
    end
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
      $error("stream_mux_n: W must be within 1..64");
    end
  endgenerate

  logic [SW-1:0] r_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_chan;

  logic [SW-1:0] w_rr_grant;
  logic          w_rr_valid;
  logic          w_fixed_valid;
  logic [SW-1:0] w_grant;
  logic          w_grant_valid;
  logic          w_acc;
  logic          w_xfer;
  logic [W-1:0]  w_in_beat;
  logic [SW-1:0] w_ptr_next;

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );

  // Out-of-range sel never matches a channel, so it yields no grant.
  always_comb begin
    w_fixed_valid = 1'b0;
    for (int i = 0; i < N; i++)
      if (sel == SW'(i))
        w_fixed_valid = in_valid[i];
  end

  assign w_grant       = (mode == MODE_FIXED) ? sel           : w_rr_grant;
  assign w_grant_valid = (mode == MODE_FIXED) ? w_fixed_valid : w_rr_valid;
  assign w_xfer        = w_acc && w_grant_valid && !rst;
  assign w_ptr_next    = (w_grant == SW'(N-1)) ? '0 : w_grant + SW'(1);

  always_comb begin
    w_in_beat = '0;
    in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) begin
        w_in_beat   = in_data[i*W +: W];
        in_ready[i] = w_xfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_xfer && mode == MODE_RR)
      r_ptr <= w_ptr_next;
  end

`ifdef STREAM_MUX_SKID_EN
  logic          r_skid_full;
  logic [W-1:0]  r_skid_data;
  logic [SW-1:0] r_skid_chan;

  // Acceptance depends only on skid occupancy, cutting the out_ready path.
  assign w_acc = !r_skid_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_skid_full <= 1'b0;
      r_skid_data <= '0;
      r_skid_chan <= '0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_full) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        r_out_chan  <= r_skid_chan;
        r_skid_full <= 1'b0;
      end else if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_in_beat;
        r_out_chan  <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_xfer) begin
      r_skid_full <= 1'b1;
      r_skid_data <= w_in_beat;
      r_skid_chan <= w_grant;
    end
  end
`else
  assign w_acc = !r_out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_in_beat;
      r_out_chan  <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_n.sv
// ============================================================================
// Module      : tb_stream_mux_n
// Description : Self-checking bench for stream_mux_n (queue-based model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux_n;
  import stream_mux_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int N6 = 6;
`ifdef STREAM_MUX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  logic [N6*W-1:0] in_data6;
  logic [N6-1:0]   in_valid6;
  logic [N6-1:0]   in_ready6;
  logic [2:0]      sel6;
  logic [W-1:0]    out_data6;
  logic [2:0]      out_chan6;
  logic            out_valid6;

  always #5 clk = ~clk;

  stream_mux_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_n #(.N(N6), .W(W)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode(MODE_FIXED), .sel(sel6), .out_data(out_data6),
    .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(1'b1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] c;
  } beat_t;

  beat_t q[$];
  beat_t m_last = '0;
  int    m_ptr  = 0;
  bit    m_started = 0;

  function automatic void m_arb(input logic [N-1:0] v, input logic md,
                                input logic [SW-1:0] s, output bit ok, output int g);
    ok = 0;
    g  = 0;
    if (md == MODE_FIXED) begin
      if (int'(s) < N && v[s]) begin ok = 1; g = int'(s); end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!ok && v[idx]) begin ok = 1; g = idx; end
      end
    end
  endfunction

  function automatic bit m_acc(input logic ordy);
`ifdef STREAM_MUX_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || ordy;
`endif
  endfunction

  always @(posedge clk) begin : model_update
    bit    ok;
    bit    take;
    int    g;
    beat_t b;
    if (rst) begin
      q.delete();
      m_ptr  = 0;
      m_last = '0;
    end else begin
      m_arb(in_valid, mode, sel, ok, g);
      take = ok && m_acc(out_ready);
      if (q.size() > 0 && out_ready) m_last = q.pop_front();
      if (take) begin
        b.d = in_data[g*W +: W];
        b.c = SW'(g);
        q.push_back(b);
        if (mode == MODE_RR) m_ptr = (g + 1) % N;
      end
      if (q.size() > 0) m_last = q[0];
    end
    m_started = 1;
  end

  always @(negedge clk) begin : model_compare
    bit       ok;
    int       g;
    logic [N-1:0] exp_rdy;
    if (m_started) begin
      m_arb(in_valid, mode, sel, ok, g);
      exp_rdy = (!rst && ok && m_acc(out_ready)) ? N'(1) << g : '0;
      check("m_in_ready",  64'(in_ready),  64'(exp_rdy));
      check("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("m_out_data",  64'(out_data),  64'(m_last.d));
      check("m_out_chan",  64'(out_chan),  64'(m_last.c));
    end
  end

  // ---------------- stimulus ----------------
  int cnt = 0;

  task automatic refresh();
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = {4'(i), 4'(cnt)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cnt++;
    refresh();
  endtask

  logic [W-1:0] acc_q[$];
  logic [W-1:0] del_q[$];

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    mode      = MODE_FIXED;
    sel       = '0;
    out_ready = 1'b1;
    refresh();
    in_data6  = {N6{8'h5A}};
    in_valid6 = '1;
    sel6      = 3'd7;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check("rst_in_ready",  64'(in_ready),  64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data",  64'(out_data),  64'(0));
    end
    rst = 1'b0;
    #1;
    check("first_ready", 64'(in_ready), 64'(8'h01));
    tick();
    check("first_accept_ov", 64'(out_valid), 64'(1));
    check("first_accept_ch", 64'(out_chan),  64'(0));

    sel = 3'd3;
    in_data[3*W +: W] = 8'hA5;
    #1;
    check("fix_ready", 64'(in_ready), 64'(8'b0000_1000));
    tick();
    check("fix_data", 64'(out_data), 64'(8'hA5));
    check("fix_chan", 64'(out_chan), 64'(3));

    in_valid = 8'hF7;
    #1;
    check("fix_noval_ready", 64'(in_ready), 64'(0));
    tick();
    check("fix_noval_ov", 64'(out_valid), 64'(0));
    tick();
    check("fix_noval_ov2", 64'(out_valid), 64'(0));
    check("n6_sel7_ready", 64'(in_ready6),  64'(0));
    check("n6_sel7_ov",    64'(out_valid6), 64'(0));

    mode     = MODE_RR;
    in_valid = '1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_seq", 64'(out_chan), 64'(i % 8));
    end
    in_valid = 8'h24;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_2_5", 64'(out_chan), 64'((i % 2 == 1) ? 5 : 2));
    end

    in_valid = '0;
    mode     = MODE_FIXED;
    sel      = 3'd1;
    tick();
    check("bp_drained", 64'(out_valid), 64'(0));

    in_valid  = 8'h02;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (in_ready[1]) acc_q.push_back(in_data[1*W +: W]);
      if (i == 0) check("bp_first_ready", 64'(in_ready), 64'(8'h02));
      tick();
      check("bp_hold", 64'(out_data), 64'({4'h1, 4'(cnt - 1 - i)}));
    end
    check("bp_accepted", 64'(acc_q.size()), 64'(DEPTH));

    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) del_q.push_back(out_data);
      tick();
    end
    check("bp_delivered", 64'(del_q.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (i < del_q.size() && i < acc_q.size())
        check("bp_order", 64'(del_q[i]), 64'(acc_q[i]));

    in_valid  = 8'h02;
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    check("mid_full_ov", 64'(out_valid), 64'(1));
    rst = 1'b1;
    tick();
    check("mid_rst_ov",    64'(out_valid), 64'(0));
    check("mid_rst_data",  64'(out_data),  64'(0));
    check("mid_rst_ready", 64'(in_ready),  64'(0));
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_ghost", 64'(out_valid), 64'(0));
    end

    mode     = MODE_RR;
    in_valid = '1;
    tick();
    check("rr_ptr_reset", 64'(out_chan), 64'(0));
    in_valid = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
